// File: rtl/trig_cond_pkg.sv
// Shared definitions for the trigger conditioner: FSM state encoding,
// default widths and a small state-decoding helper.
package trig_cond_pkg;

  localparam int NBITS_DEFAULT       = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  function automatic logic is_busy(input state_t st);
    return (st == FIRE) || (st == HOLDOFF);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchronizer for the raw trigger line followed by a
// programmable-length debounce counter producing the clean level d.
module sync_debounce
  import trig_cond_pkg::*;
#(
  parameter int Nbits       = NBITS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic [Nbits-1:0] db_len,
  output logic             d
);

  localparam logic [Nbits-1:0] ONE = {{(Nbits-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [Nbits-1:0]       cnt;

  assign s = sync[SYNC_STAGES-1];

  // synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], trig_in};
    end
  end

  // debounce: d follows s only after s has differed for db_len+1 edges;
  // >= keeps the counter bounded if db_len is lowered mid-count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      d   <= 1'b0;
    end else if (s == d) begin
      cnt <= '0;
    end else if (cnt >= db_len) begin
      d   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/trigger_conditioner.sv
// Conditions an asynchronous trigger line into a single-cycle registered
// trigger pulse with edge selection, holdoff and a saturating miss counter.
module trigger_conditioner
  import trig_cond_pkg::*;
#(
  parameter int Nbits       = NBITS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic [Nbits-1:0] data,
  input  logic             load_db,
  input  logic             load_ho,
  input  logic             edge_sel,
  input  logic             enable,
  output logic             trigger,
  output logic             busy,
  output logic [Nbits-1:0] miss_cnt
);

  localparam logic [Nbits-1:0] ONE = {{(Nbits-1){1'b0}}, 1'b1};

  logic [Nbits-1:0] db_len;
  logic [Nbits-1:0] ho_len;
  logic [Nbits-1:0] ho_cnt;
  logic [Nbits:0]   ho_cnt_nx;
  logic             ho_done;
  logic             d;
  logic             d_prev;
  logic             q;
  state_t           state;
  state_t           next_state;

  function automatic logic [Nbits-1:0] sat_inc(input logic [Nbits-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_len <= '0;
      ho_len <= '0;
    end else begin
      if (load_db) db_len <= data;
      if (load_ho) ho_len <= data;
    end
  end

  sync_debounce #(
    .Nbits       (Nbits),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sd (
    .clk     (clk),
    .rst     (rst),
    .trig_in (trig_in),
    .db_len  (db_len),
    .d       (d)
  );

  // edge detect on the debounced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_prev <= 1'b0;
    end else begin
      d_prev <= d;
    end
  end

  assign q = edge_sel ? (~d & d_prev) : (d & ~d_prev);

  // widened compare so a shrinking or zeroed ho_len still ends holdoff
  assign ho_cnt_nx = {1'b0, ho_cnt} + {{Nbits{1'b0}}, 1'b1};
  assign ho_done   = ho_cnt_nx >= {1'b0, ho_len};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = ARMED;
      ARMED: begin
        if (!enable) next_state = IDLE;
        else if (q)  next_state = FIRE;
      end
      FIRE: begin
        if (!enable)            next_state = IDLE;
        else if (ho_len != '0)  next_state = HOLDOFF;
        else                    next_state = ARMED;
      end
      HOLDOFF: begin
        if (!enable)      next_state = IDLE;
        else if (ho_done) next_state = ARMED;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ho_cnt <= '0;
    end else if (state == HOLDOFF) begin
      ho_cnt <= ho_cnt_nx[Nbits-1:0];
    end else begin
      ho_cnt <= '0;
    end
  end

  // registered outputs track the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trigger  <= 1'b0;
      busy     <= 1'b0;
      miss_cnt <= '0;
    end else begin
      trigger <= (next_state == FIRE);
      busy    <= is_busy(next_state);
      if (q && is_busy(state)) miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner: each task drives one scenario and
// checks outputs against hand-derived cycle positions and counts.
module tb_trigger_conditioner;
  import trig_cond_pkg::*;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          trig_in = 1'b0;
  logic [NB-1:0] data = '0;
  logic          load_db = 1'b0;
  logic          load_ho = 1'b0;
  logic          edge_sel = 1'b0;
  logic          enable = 1'b0;
  logic          trigger;
  logic          busy;
  logic [NB-1:0] miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  trigger_conditioner #(.Nbits(NB), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .trig_in  (trig_in),
    .data     (data),
    .load_db  (load_db),
    .load_ho  (load_ho),
    .edge_sel (edge_sel),
    .enable   (enable),
    .trigger  (trigger),
    .busy     (busy),
    .miss_cnt (miss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // advance n cycles, tallying trigger pulses, first trigger cycle and busy cycles
  task automatic run(input int n, output int ntrig, output int first, output int nbusy);
    ntrig = 0;
    first = -1;
    nbusy = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (trigger === 1'b1) begin
        ntrig++;
        if (first < 0) first = i;
      end
      if (busy === 1'b1) nbusy++;
    end
  endtask

  task automatic set_len(input logic [NB-1:0] db, input logic [NB-1:0] ho);
    data = db;
    load_db = 1'b1;
    tick();
    load_db = 1'b0;
    data = ho;
    load_ho = 1'b1;
    tick();
    load_ho = 1'b0;
  endtask

  task automatic test_reset();
    int nt, fp, nb;
    #2 rst = 1'b1;
    #2;
    vectors++; if (trigger !== 1'b0) begin miscompares++; $display("FAIL reset_trigger: got %b want 0", trigger); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (miss_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_miss: got %0d want 0", miss_cnt); end
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    // trig_in already high when reset releases: one trigger after debounce
    trig_in = 1'b1;
    enable = 1'b1;
    edge_sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(12, nt, fp, nb);
    vectors++; if (nt != 1) begin miscompares++; $display("FAIL high_at_release_count: got %0d want 1", nt); end
    vectors++; if (fp != 4) begin miscompares++; $display("FAIL high_at_release_cycle: got %0d want 4", fp); end
    trig_in = 1'b0;
    run(8, nt, fp, nb);
    vectors++; if (nt != 0) begin miscompares++; $display("FAIL fall_no_fire: got %0d want 0", nt); end
  endtask

  task automatic test_load();
    data = 8'd3;
    load_db = 1'b1;
    load_ho = 1'b1;
    tick();
    load_db = 1'b0;
    load_ho = 1'b0;
    vectors++; if (dut.db_len !== 8'd3) begin miscompares++; $display("FAIL load_both_db: got %0d want 3", dut.db_len); end
    vectors++; if (dut.ho_len !== 8'd3) begin miscompares++; $display("FAIL load_both_ho: got %0d want 3", dut.ho_len); end
    data = 8'd5;
    load_db = 1'b1;
    tick();
    load_db = 1'b0;
    vectors++; if (dut.db_len !== 8'd5) begin miscompares++; $display("FAIL load_db_only: got %0d want 5", dut.db_len); end
    vectors++; if (dut.ho_len !== 8'd3) begin miscompares++; $display("FAIL load_ho_kept: got %0d want 3", dut.ho_len); end
  endtask

  task automatic test_rise();
    int nt, fp, nb;
    set_len(8'd3, 8'd0);
    trig_in = 1'b1;
    run(12, nt, fp, nb);
    vectors++; if (nt != 1) begin miscompares++; $display("FAIL rise_count: got %0d want 1", nt); end
    vectors++; if (fp != 7) begin miscompares++; $display("FAIL rise_latency: got %0d want 7", fp); end
    vectors++; if (nb != 1) begin miscompares++; $display("FAIL rise_busy_len: got %0d want 1", nb); end
    trig_in = 1'b0;
    run(10, nt, fp, nb);
  endtask

  task automatic test_glitch();
    int nt, fp, nb, tot;
    set_len(8'd4, 8'd0);
    trig_in = 1'b1;
    run(3, nt, fp, nb);
    tot = nt;
    trig_in = 1'b0;
    run(12, nt, fp, nb);
    tot += nt;
    vectors++; if (tot != 0) begin miscompares++; $display("FAIL glitch_trigger: got %0d want 0", tot); end
    vectors++; if (miss_cnt !== 8'd0) begin miscompares++; $display("FAIL glitch_miss: got %0d want 0", miss_cnt); end
    // db_len+1 cycles is just long enough to pass
    trig_in = 1'b1;
    run(5, nt, fp, nb);
    tot = nt;
    trig_in = 1'b0;
    run(15, nt, fp, nb);
    tot += nt;
    vectors++; if (tot != 1) begin miscompares++; $display("FAIL min_pulse_trigger: got %0d want 1", tot); end
  endtask

  task automatic test_holdoff();
    int nt, fp, nb, tt, tb;
    set_len(8'd0, 8'd10);
    tt = 0;
    tb = 0;
    for (int k = 0; k < 3; k++) begin
      trig_in = 1'b1;
      run(2, nt, fp, nb);
      tt += nt; tb += nb;
      trig_in = 1'b0;
      run(3, nt, fp, nb);
      tt += nt; tb += nb;
    end
    run(8, nt, fp, nb);
    tt += nt; tb += nb;
    vectors++; if (tt != 1) begin miscompares++; $display("FAIL holdoff_triggers: got %0d want 1", tt); end
    vectors++; if (tb != 11) begin miscompares++; $display("FAIL holdoff_busy_len: got %0d want 11", tb); end
    vectors++; if (miss_cnt !== 8'd2) begin miscompares++; $display("FAIL holdoff_miss: got %0d want 2", miss_cnt); end
    trig_in = 1'b1;
    run(2, nt, fp, nb);
    tt = nt;
    trig_in = 1'b0;
    run(14, nt, fp, nb);
    tt += nt;
    vectors++; if (tt != 1) begin miscompares++; $display("FAIL after_holdoff_fire: got %0d want 1", tt); end
  endtask

  task automatic test_saturate();
    int nt, fp, nb;
    set_len(8'd0, 8'd0);
    // edge_sel tracks the fresh trig_in level so every cycle carries a
    // qualified edge, half of them landing in FIRE
    for (int i = 0; i < 700; i++) begin
      trig_in = ~trig_in;
      edge_sel = trig_in;
      tick();
    end
    vectors++; if (miss_cnt !== 8'd255) begin miscompares++; $display("FAIL miss_saturate: got %0d want 255", miss_cnt); end
    trig_in = 1'b0;
    edge_sel = 1'b0;
    run(6, nt, fp, nb);
  endtask

  task automatic test_reset_holdoff();
    int nt, fp, nb;
    set_len(8'd0, 8'd10);
    trig_in = 1'b1;
    run(2, nt, fp, nb);
    trig_in = 1'b0;
    run(5, nt, fp, nb);
    vectors++; if (dut.state !== HOLDOFF) begin miscompares++; $display("FAIL pre_rst_state: got %0d want %0d", dut.state, HOLDOFF); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pre_rst_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (trigger !== 1'b0) begin miscompares++; $display("FAIL rst_trigger: got %b want 0", trigger); end
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want %0d", dut.state, IDLE); end
    vectors++; if (dut.db_len !== 8'd0) begin miscompares++; $display("FAIL rst_db_len: got %0d want 0", dut.db_len); end
    vectors++; if (dut.ho_len !== 8'd0) begin miscompares++; $display("FAIL rst_ho_len: got %0d want 0", dut.ho_len); end
    vectors++; if (miss_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_miss: got %0d want 0", miss_cnt); end
    @(negedge clk);
    rst = 1'b0;
    run(10, nt, fp, nb);
    vectors++; if (nt != 0) begin miscompares++; $display("FAIL rst_release_trigger: got %0d want 0", nt); end
  endtask

  task automatic test_enable_drop();
    int nt, fp, nb;
    set_len(8'd0, 8'd0);
    edge_sel = 1'b1;
    enable = 1'b1;
    trig_in = 1'b1;
    run(8, nt, fp, nb);
    vectors++; if (nt != 0) begin miscompares++; $display("FAIL fall_mode_rise: got %0d want 0", nt); end
    trig_in = 1'b0;
    run(3, nt, fp, nb);
    // qualified falling edge is present in the cycle enable drops
    enable = 1'b0;
    run(6, nt, fp, nb);
    vectors++; if (nt != 0) begin miscompares++; $display("FAIL disable_trigger: got %0d want 0", nt); end
    vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL disable_state: got %0d want %0d", dut.state, IDLE); end
    enable = 1'b1;
    trig_in = 1'b1;
    run(8, nt, fp, nb);
    trig_in = 1'b0;
    run(8, nt, fp, nb);
    vectors++; if (nt != 1) begin miscompares++; $display("FAIL reenable_count: got %0d want 1", nt); end
    vectors++; if (fp != 4) begin miscompares++; $display("FAIL reenable_latency: got %0d want 4", fp); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_rise();
    test_glitch();
    test_holdoff();
    test_saturate();
    test_reset_holdoff();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
